// File: rtl/systolic_mm_nxn.sv
// N x N output-stationary systolic matrix multiplier.
// Unskewed A columns / B rows in; C accumulates in place and is read from c_flat.
module systolic_mm_nxn #(
    parameter int N      = 4,
    parameter int DW     = 4,
    parameter int AW     = 2 * DW + $clog2(N),
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              acc_mode,
    input  logic              in_valid,
    input  logic [N*DW-1:0]   a_col,
    input  logic [N*DW-1:0]   b_row,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [N*N*AW-1:0] c_flat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CW = $clog2(2 * N);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          beat, en, clr_pipe, clr_acc;

    assign beat     = (state == S_LOAD) && in_valid;
    assign en       = beat || (state == S_DRAIN);
    assign clr_pipe = (state == S_IDLE) && start;
    assign clr_acc  = clr_pipe && !acc_mode;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts accepted beats in LOAD, then drain cycles in DRAIN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt == CW'(N - 1)) begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt == CW'(2 * N - 3)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    function automatic logic [AW-1:0] mul(input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
        logic        [2*DW-1:0] pu;
        logic signed [2*DW-1:0] ps;
        pu = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        ps = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
        if (SIGNED != 0) return AW'(ps);
        return AW'(pu);
    endfunction

    logic [N*DW-1:0] a_sk, b_sk;

    // Row i of A and column i of B are delayed i enabled cycles; zeros fill behind the last beat
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_src, b_src;
        assign a_src = beat ? a_col[i*DW +: DW] : '0;
        assign b_src = beat ? b_row[i*DW +: DW] : '0;
        if (i == 0) begin : g_d0
            assign a_sk[0 +: DW] = a_src;
            assign b_sk[0 +: DW] = b_src;
        end else begin : g_dn
            logic [DW-1:0] a_sr [i];
            logic [DW-1:0] b_sr [i];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else if (clr_pipe) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else if (en) begin
                    a_sr[0] <= a_src;
                    b_sr[0] <= b_src;
                    for (int d = 1; d < i; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end
            assign a_sk[i*DW +: DW] = a_sr[i-1];
            assign b_sk[i*DW +: DW] = b_sr[i-1];
        end
    end

    logic [N*(N-1)*DW-1:0] a_r;
    logic [(N-1)*N*DW-1:0] b_r;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [DW-1:0] ai, bi;
            logic [AW-1:0] acc;

            if (gj == 0) begin : g_aw
                assign ai = a_sk[gi*DW +: DW];
            end else begin : g_ai
                assign ai = a_r[(gi*(N-1)+gj-1)*DW +: DW];
            end
            if (gi == 0) begin : g_bn
                assign bi = b_sk[gj*DW +: DW];
            end else begin : g_bi
                assign bi = b_r[((gi-1)*N+gj)*DW +: DW];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)        acc <= '0;
                else if (clr_acc) acc <= '0;
                else if (en)      acc <= acc + mul(ai, bi);
            end
            assign c_flat[(gi*N+gj)*AW +: AW] = acc;

            if (gj < N - 1) begin : g_ap
                logic [DW-1:0] ar;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)         ar <= '0;
                    else if (clr_pipe) ar <= '0;
                    else if (en)       ar <= ai;
                end
                assign a_r[(gi*(N-1)+gj)*DW +: DW] = ar;
            end
            if (gi < N - 1) begin : g_bp
                logic [DW-1:0] br;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)         br <= '0;
                    else if (clr_pipe) br <= '0;
                    else if (en)       br <= bi;
                end
                assign b_r[(gi*N+gj)*DW +: DW] = br;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Scoreboard bench: unsigned and signed instances share stimulus;
// expected C comes from plain matrix arithmetic on the issued operands.
module tb_systolic_mm_nxn;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int AW  = 10;
    localparam int CWF = N * N * AW;

    logic clk = 1'b0;
    logic reset, start, acc_mode, in_valid;
    logic [N*DW-1:0] a_col, b_row;
    logic rdy_u, busy_u, done_u, rdy_s, busy_s, done_s;
    logic [CWF-1:0] c_u, c_s;

    always #5 clk = ~clk;

    systolic_mm_nxn #(.N(N), .DW(DW), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
        .in_valid(in_valid), .a_col(a_col), .b_row(b_row),
        .in_ready(rdy_u), .busy(busy_u), .done(done_u), .c_flat(c_u)
    );

    systolic_mm_nxn #(.N(N), .DW(DW), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
        .in_valid(in_valid), .a_col(a_col), .b_row(b_row),
        .in_ready(rdy_s), .busy(busy_s), .done(done_s), .c_flat(c_s)
    );

    typedef struct {
        logic [CWF-1:0] cu;
        logic [CWF-1:0] cs;
        int             when;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int am [N][N];
    int bm [N][N];
    logic [AW-1:0] pu [N][N];
    logic [AW-1:0] ps [N][N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [CWF-1:0] got,
                       input logic [CWF-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic logic [CWF-1:0] flat(input bit sgn);
        logic [CWF-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                f[(i*N+j)*AW +: AW] = sgn ? ps[i][j] : pu[i][j];
        return f;
    endfunction

    function automatic logic [CWF-1:0] const_flat(input logic [AW-1:0] v);
        logic [CWF-1:0] f;
        for (int e = 0; e < N * N; e++) f[e*AW +: AW] = v;
        return f;
    endfunction

    function automatic logic [CWF-1:0] id_flat();
        logic [CWF-1:0] f;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                f[(i*N+j)*AW +: AW] = AW'(j + 1);
        return f;
    endfunction

    // C = (acc ? C : 0) + A*B, modulo 2^AW, in both interpretations
    task automatic predict(input logic accm, input int cs0, input int gaps);
        exp_t e;
        int su, ss;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                su = 0;
                ss = 0;
                for (int k = 0; k < N; k++) begin
                    su += am[i][k] * bm[k][j];
                    ss += sx(am[i][k]) * sx(bm[k][j]);
                end
                if (!accm) begin
                    pu[i][j] = '0;
                    ps[i][j] = '0;
                end
                pu[i][j] = pu[i][j] + AW'(su);
                ps[i][j] = ps[i][j] + AW'(ss);
            end
        e.cu = flat(1'b0);
        e.cs = flat(1'b1);
        e.when = cs0 + 3 * N - 2 + gaps;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (done_u || done_s)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done cyc=%0d got u=%b s=%b want 0",
                         cyc, done_u, done_s);
            end else begin
                e = sb.pop_front();
                chk("done_u", CWF'(done_u), CWF'(1'b1));
                chk("done_s", CWF'(done_s), CWF'(1'b1));
                chk("c_unsigned", c_u, e.cu);
                chk("c_signed", c_s, e.cs);
                chk("latency", CWF'(cyc), CWF'(e.when));
            end
        end
    end

    task automatic set_id();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = k + 1;
                bm[i][k] = (i == k) ? 1 : 0;
            end
    endtask

    task automatic set_all(input int a, input int b);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = a;
                bm[i][k] = b;
            end
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = int'($urandom_range(0, 15));
                bm[i][k] = int'($urandom_range(0, 15));
            end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 100 && sb.size() > 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout got pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic accm, input int gpos, input int glen,
                       input bit stray, input int abort_c);
        int cs0;
        @(negedge clk);
        start = 1'b1;
        acc_mode = accm;
        @(negedge clk);
        start = 1'b0;
        acc_mode = 1'($urandom);
        cs0 = cyc;
        chk("busy_load", CWF'(busy_u), CWF'(1'b1));
        chk("ready_load", CWF'(rdy_u), CWF'(1'b1));
        predict(accm, cs0, glen);
        for (int k = 0; k < N; k++) begin
            if (k == gpos) begin
                for (int g = 0; g < glen; g++) begin
                    in_valid = 1'b0;
                    a_col = (N*DW)'($urandom);
                    b_row = (N*DW)'($urandom);
                    chk("ready_gap", CWF'(rdy_u), CWF'(1'b1));
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = DW'(am[i][k]);
                b_row[i*DW +: DW] = DW'(bm[k][i]);
            end
            if (stray && k == 1) begin
                start = 1'b1;
                acc_mode = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("ready_drain", CWF'(rdy_u), CWF'(1'b0));
        if (abort_c > 0) begin
            for (int c = 1; c < abort_c; c++) @(negedge clk);
            reset = 1'b1;
            start = 1'b1;
            #1;
            chk("abort_cu", c_u, '0);
            chk("abort_cs", c_s, '0);
            chk("abort_busy", CWF'(busy_u), CWF'(1'b0));
            chk("abort_done", CWF'(done_u), CWF'(1'b0));
            chk("abort_ready", CWF'(rdy_u), CWF'(1'b0));
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            sb.delete();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pu[i][j] = '0;
                    ps[i][j] = '0;
                end
            repeat (15) @(negedge clk);
        end else begin
            wait_done();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        acc_mode = 1'b0;
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                pu[i][j] = '0;
                ps[i][j] = '0;
            end
        repeat (3) @(negedge clk);
        chk("rst_cu", c_u, '0);
        chk("rst_busy", CWF'(busy_u), CWF'(1'b0));
        chk("rst_ready", CWF'(rdy_u), CWF'(1'b0));
        chk("rst_done", CWF'(done_u), CWF'(1'b0));
        reset = 1'b0;

        set_id();
        run(1'b0, -1, 0, 1'b1, 0);
        chk("identity", c_u, id_flat());

        set_all(15, 15);
        run(1'b0, -1, 0, 1'b0, 0);
        chk("all15", c_u, const_flat(AW'(900)));
        run(1'b1, -1, 0, 1'b0, 0);
        chk("all15_acc", c_u, const_flat(AW'(776)));

        set_all(8, 8);
        run(1'b0, -1, 0, 1'b0, 0);
        chk("neg8_neg8", c_s, const_flat(AW'(256)));
        set_all(8, 7);
        run(1'b0, -1, 0, 1'b0, 0);
        chk("neg8_pos7", c_s, const_flat(AW'(-224)));

        set_id();
        run(1'b0, 2, 3, 1'b0, 0);
        chk("identity_gap", c_u, id_flat());

        run(1'b1, -1, 0, 1'b0, 2);
        run(1'b0, -1, 0, 1'b0, 0);
        chk("identity_after_abort", c_u, id_flat());

        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            a_col = (N*DW)'($urandom);
            b_row = (N*DW)'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("idle_hold_u", c_u, flat(1'b0));
        chk("idle_hold_s", c_s, flat(1'b1));
        chk("idle_busy", CWF'(busy_u), CWF'(1'b0));

        for (int r = 0; r < 10; r++) begin
            set_rand();
            run(1'($urandom), int'($urandom_range(1, N - 1)),
                int'($urandom_range(0, 3)), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_mm_nxn.md
SYSTOLIC_MM_NXN -- requirements
Module: systolic_mm_nxn

Interface
REQ-001 Parameter N, default 4, array dimension (N x N PEs), legal 2..8.
REQ-002 Parameter DW, default 4, operand width in bits.
REQ-003 Parameter AW, default 2*DW+$clog2(N), accumulator and result width.
REQ-004 Parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands and results.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request a new matrix multiply; sampled only in IDLE.
REQ-008 acc_mode  input  1  sampled with start; 1 = keep previous C (C += A*B), 0 = clear C.
REQ-009 in_valid  input  1  beat qualifier for a_col/b_row.
REQ-010 a_col  input  N*DW  beat k: A[i][k] at bits [i*DW +: DW].
REQ-011 b_row  input  N*DW  beat k: B[k][j] at bits [j*DW +: DW].
REQ-012 in_ready  output  1  high in LOAD only.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when results are final.
REQ-015 c_flat  output  N*N*AW  C[i][j] at bits [(i*N+j)*AW +: AW].

Function
REQ-016 FSM states IDLE, LOAD, DRAIN, DONE; encoding free.
REQ-017 IDLE -> LOAD on start=1; accumulators clear on that edge when acc_mode=0, otherwise hold.
REQ-018 start in any other state is ignored; acc_mode is ignored outside the start edge.
REQ-019 LOAD accepts a beat on each edge with in_valid=1 and in_ready=1; beats are unskewed, and the block skews internally: row i of A delayed i enabled cycles, column j of B delayed j enabled cycles.
REQ-020 Array enable = (LOAD and in_valid) or DRAIN; with enable low, all skew, pass-through and accumulator registers hold (in_valid gaps are stalls, not zero beats).
REQ-021 LOAD -> DRAIN on the edge accepting beat N-1; DRAIN lasts exactly 2N-2 cycles, then -> DONE.
REQ-022 Each PE(i,j) registers its A input rightward and its B input downward, and adds A*B to its accumulator on each enabled edge; products use DW x DW full-width multiply with signedness per SIGNED.
REQ-023 Accumulators wrap modulo 2^AW (no saturation); with default AW, a single run cannot overflow.
REQ-024 Skew and pipeline registers are zero-filled behind the last beat, so drain adds zero products.
REQ-025 DONE lasts one cycle with done=1, then -> IDLE; done=0 at all other times.
REQ-026 Latency with no stalls: done high in the cycle following the (3N-2)th edge after the start edge (N=4: edge 10).
REQ-027 c_flat is driven directly from the accumulators; it is final from the DONE cycle and holds until the next start edge (or after it, if acc_mode=1).
REQ-028 in_valid outside LOAD is ignored.

Reset
REQ-029 reset=1 immediately forces IDLE; in_ready=0, busy=0, done=0, all accumulators, skew and PE registers = 0, so c_flat=0.
REQ-030 Reset asserted mid-LOAD or mid-DRAIN aborts the run with no done pulse; the first start after release behaves as from power-up.

Verification
REQ-031 N=4, DW=4, SIGNED=0: A=[[1,2,3,4] per row], B=identity, 4 beats back-to-back -> done at edge 10, C[i][j]=j+1 for every i.
REQ-032 All operands 15 (unsigned) -> every C[i][j]=900; then a second run with acc_mode=1 and the same data -> every C[i][j]=(1800 mod 1024)=776.
REQ-033 SIGNED=1, all A=-8, all B=-8 -> every C[i][j]=256; A=-8, B=7 -> every C[i][j]=-224 (two's complement, AW=10).
REQ-034 Identity-matrix test with in_valid low for 3 cycles between beats 1 and 2 -> results identical to REQ-031, done exactly 3 cycles later; in_ready stays 1 during the gaps.
REQ-035 reset pulsed in DRAIN cycle 2 -> outputs zero immediately, no done; start ignored while busy; a fresh run then reproduces REQ-031 exactly.
